cfs_apb_arbiter_master: RTL

Multi-requester APB master. Arbitrates round-robin between NUM_REQ local requesters and drives one APB bus (paddr/pwrite/psel/penable/pwdata, sampling pready/prdata/pslverr). It sequences the SETUP/ACCESS phases, handles slave wait states, and aborts stalled transfers with a programmable timeout. It sits between on-chip initiators and the APB interconnect that feeds the APB slaves.

---
 rtl/cfs_apb_arbiter_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cfs_apb_arbiter_master.sv
// cfs_apb_arbiter_master
// Round-robin arbiter in front of a single APB master. One transfer is in
// flight at a time: IDLE -> SETUP -> ACCESS (wait states / timeout) -> RESP.
module cfs_apb_arbiter_master #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                            pclk,
    input  logic                            reset,
    // local requesters
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            rsp_timeout,
    output logic                            busy,
    // APB master side
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic                            pwrite,
    output logic                            psel,
    output logic                            penable,
    output logic [DATA_WIDTH-1:0]           pwdata,
    input  logic                            pready,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_tmo;

    int                    w_idx;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_grant_found;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_cnt_hit;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic [NUM_REQ-1:0]    w_rsp_valid;

    // Round-robin pick: scan from the highest offset down so the requester
    // closest to the pointer is the last (and winning) assignment.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        w_sel         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = IDX_W'(w_idx);
            if (req_valid[w_sel]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_sel;
            end
        end
    end

    assign w_ptr_nxt = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_cnt_hit = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

    // One-hot accept in IDLE and one-hot completion pulse in RESP.
    always_comb begin
        w_req_ready = '0;
        w_rsp_valid = '0;
        if (r_state == S_IDLE && w_grant_found) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
        if (r_state == S_RESP) begin
            w_rsp_valid[r_id] = 1'b1;
        end
    end

    // Transfer sequencer: capture on accept, wait for pready or timeout,
    // latch the response, then return to IDLE.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_addr  <= req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= req_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_write <= req_write[w_grant_idx];
                        r_id    <= w_grant_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    // pready wins over a timeout landing in the same cycle
                    if (pready) begin
                        r_rsp_rdata <= r_write ? '0 : prdata;
                        r_rsp_err   <= pslverr;
                        r_rsp_tmo   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (w_cnt_hit) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_tmo   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus phase outputs decode straight from the state register so that
    // reset removes psel/penable without waiting for a clock edge.
    assign psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable     = (r_state == S_ACCESS);
    assign paddr       = r_addr;
    assign pwrite      = r_write;
    assign pwdata      = r_wdata;
    assign busy        = (r_state != S_IDLE);
    assign req_ready   = w_req_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_tmo;

endmodule
